// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath: the instruction
// register and halt request flow in, bus-drive/load enables and ALU select
// flow out.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        Stop;
  logic        PCout, Zlowout, MDRout;
  logic        MARin, PCin, MDRin, IRin, Yin, ZLowIn;
  logic        IncPC, Read;
  logic [4:0]  ALU_op;
  logic        Gra, Grb, Grc, Rin, Rout, Cout;
  logic        Run;

  modport master (
    input  IR, Stop,
    output PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZLowIn,
           IncPC, Read, ALU_op, Gra, Grb, Grc, Rin, Rout, Cout, Run
  );

  modport slave (
    output IR, Stop,
    input  PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZLowIn,
           IncPC, Read, ALU_op, Gra, Grb, Grc, Rin, Rout, Cout, Run
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer: three-step fetch (T0..T2), then a three-step
// execute (T3..T5) for reg-reg ALU ops and addi, or a Halt state. Outputs
// depend only on the current state and the opcode captured on leaving T2.
module control_sequencer (
  input  logic              Clock,
  input  logic              Clear,
  control_sequencer_if.master bus
);

  localparam logic [2:0] RESET_STATE = 3'd0;
  localparam logic [2:0] T0          = 3'd1;
  localparam logic [2:0] T1          = 3'd2;
  localparam logic [2:0] T2          = 3'd3;
  localparam logic [2:0] T3          = 3'd4;
  localparam logic [2:0] T4          = 3'd5;
  localparam logic [2:0] T5          = 3'd6;
  localparam logic [2:0] HALT        = 3'd7;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic [2:0] state;
  logic [2:0] state_next;
  logic [4:0] opcode;
  logic [4:0] ir_op;

  // Opcodes that run the T3..T5 execute sequence.
  function automatic logic is_exec_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_ADDI);
  endfunction

  assign ir_op = bus.IR[31:27];

  // Next-state selection; Stop is only honoured at the two instruction
  // boundaries (leaving T2 and leaving T5) so an instruction never stops
  // half-way through its register write.
  always_comb begin
    state_next = RESET_STATE;
    case (state)
      RESET_STATE: state_next = T0;
      T0:          state_next = T1;
      T1:          state_next = T2;
      T2: begin
        if (bus.Stop || ir_op == OP_HALT) state_next = HALT;
        else if (is_exec_op(ir_op))       state_next = T3;
        else                              state_next = T0;
      end
      T3:          state_next = T4;
      T4:          state_next = T5;
      T5:          state_next = bus.Stop ? HALT : T0;
      HALT:        state_next = HALT;
      default:     state_next = RESET_STATE;
    endcase
  end

  // State register; Clear aborts whatever is in flight.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state <= RESET_STATE;
    else       state <= state_next;
  end

  // Capture the opcode on leaving T2 so later IR changes cannot disturb
  // the execute steps.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear)           opcode <= 5'b00000;
    else if (state == T2) opcode <= ir_op;
  end

  // Output decode from state and captured opcode.
  always_comb begin
    bus.PCout   = 1'b0;
    bus.Zlowout = 1'b0;
    bus.MDRout  = 1'b0;
    bus.MARin   = 1'b0;
    bus.PCin    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.IRin    = 1'b0;
    bus.Yin     = 1'b0;
    bus.ZLowIn  = 1'b0;
    bus.IncPC   = 1'b0;
    bus.Read    = 1'b0;
    bus.ALU_op  = 5'b00000;
    bus.Gra     = 1'b0;
    bus.Grb     = 1'b0;
    bus.Grc     = 1'b0;
    bus.Rin     = 1'b0;
    bus.Rout    = 1'b0;
    bus.Cout    = 1'b0;
    bus.Run     = 1'b1;
    case (state)
      T0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.ZLowIn = 1'b1;
      end
      T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      T3: begin
        bus.Grb  = 1'b1;
        bus.Rout = 1'b1;
        bus.Yin  = 1'b1;
      end
      T4: begin
        bus.ZLowIn = 1'b1;
        if (opcode == OP_ADDI) begin
          bus.Cout   = 1'b1;
          bus.ALU_op = OP_ADD;
        end else begin
          bus.Grc    = 1'b1;
          bus.Rout   = 1'b1;
          bus.ALU_op = opcode;
        end
      end
      T5: begin
        bus.Zlowout = 1'b1;
        bus.Gra     = 1'b1;
        bus.Rin     = 1'b1;
      end
      HALT:    bus.Run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset; ports are listed below, clock and reset first.
REQ-002 Clock  in  1  Rising-edge system clock shared with the datapath.
REQ-003 Clear  in  1  Asynchronous active-high reset.
REQ-004 IR  in  32  Datapath instruction register: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-005 Stop  in  1  External halt request.
REQ-006 PCout, Zlowout, MDRout  out  1 each  Datapath bus-drive enables.
REQ-007 MARin, PCin, MDRin, IRin, Yin, ZLowIn  out  1 each  Datapath register load enables.
REQ-008 IncPC, Read  out  1 each  Datapath PC-increment select and memory read.
REQ-009 ALU_op  out  5  ALU operation select to the datapath.
REQ-010 Gra, Grb, Grc, Rin, Rout, Cout  out  1 each  Register-select field choose, general-register in/out, sign-extended-immediate bus drive.
REQ-011 Run  out  1  High while sequencing; low in Halt.

Function
REQ-012 SHALL be a Moore FSM: states Reset_state, T0, T1, T2, T3, T4, T5, Halt; one state per Clock rising edge; outputs decoded from state (and latched IR) only.
REQ-013 SHALL assert no output in Reset_state except Run=1; Reset_state->T0 unconditionally.
REQ-014 T0 SHALL assert PCout, MARin, IncPC, ZLowIn; ALU_op=00000.
REQ-015 T1 SHALL assert Zlowout, PCin, Read, MDRin.
REQ-016 T2 SHALL assert MDRout, IRin.
REQ-017 SHALL decode IR at end of T2 (value loaded in T2 visible at next edge): 00011 add, 00100 sub, 00101 and, 00110 or (reg-reg); 01100 addi; 11011 halt; all others illegal.
REQ-018 Reg-reg/addi: T3 SHALL assert Grb, Rout, Yin.
REQ-019 Reg-reg: T4 SHALL assert Grc, Rout, ZLowIn, ALU_op=opcode.
REQ-020 Addi: T4 SHALL assert Cout, ZLowIn, ALU_op=00011.
REQ-021 Reg-reg/addi: T5 SHALL assert Zlowout, Gra, Rin; then T5->T0.
REQ-022 Halt opcode: T2->Halt; illegal opcode: T2->T0 (no register written, PC already incremented).
REQ-023 Halt SHALL drive all enables 0, ALU_op=0, Run=0; remain until Clear.
REQ-024 Stop sampled high on the edge leaving T2 or T5 SHALL go to Halt instead of T3/T0; Stop in other states ignored (instruction completes).
REQ-025 At most one bus-drive enable (PCout, Zlowout, MDRout, Rout, Cout) SHALL be high in any state.
REQ-026 ALU_op SHALL be 00000 in every state except T4.
REQ-027 Opcode used in T3-T5 SHALL be latched at T2 exit and not follow later IR changes.

Reset
REQ-028 Clear high SHALL force Reset_state immediately (no clock), all enables 0, ALU_op=0, Run=1.
REQ-029 Clear mid-instruction (any Tn or Halt) SHALL abort; first edge after Clear deasserts enters T0.
REQ-030 Latched opcode SHALL reset to 00000.

Verification
REQ-031 Clear pulse, then IR=0x1A920000 (add R5,R2,R4) -> states T0..T5 over 6 edges; T4 ALU_op=00011 with Grc,Rout,ZLowIn; T5 Zlowout,Gra,Rin; next T0.
REQ-032 IR=0x62800005 (addi) -> T4 Cout=1, Rout=0, ALU_op=00011; returns to T0 after T5.
REQ-033 IR=0xD8000000 (halt) -> Halt after T2, Run=0, all enables 0 for 10 clocks; Clear restores Run=1, T0.
REQ-034 IR=0xF8000000 (illegal) -> T2->T0, Rin never asserted.
REQ-035 Stop high during T4 -> T5 completes, then Halt; Clear asserted mid-T3 -> outputs 0 asynchronously, T0 after release.
REQ-036 Every state checked: at most one bus driver high; ALU_op=0 outside T4.
